mod_red_sm2_512b: RTL and testbench

- Sequential modular reducer for the SM2 prime p = 2^256 - 2^224 - 2^96 + 2^64 - 1.
- Consumes the 512-bit product from the 256b multiplier and returns a 256-bit residue in [0, p).
- Sits directly downstream of the multiplier: multiplier finish pulse drives red_vld_i, multiplier product drives red_a_i.
- Reduces by iterative high-half folding, using 2^256 ≡ 2^224 + 2^96 - 2^64 + 1 (mod p), followed by one conditional subtraction of p.

---
 rtl/mod_red_sm2_512b.sv | 128 ++++++++++++
 tb/tb_mod_red_sm2_512b.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_red_sm2_512b.sv
// SM2 modular reducer: folds a 512-bit product down to 256 bits, then one conditional subtract of p.
// Latency 3+F cycles (2+F with RED_LAZY_OUT_EN, which skips the final subtract); starts ignored while busy.
module mod_red_sm2_512b #(
   parameter logic [255:0] SM2_P      = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF,
   parameter int           FOLD_LIMIT = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         red_vld_i,
   input  logic [511:0] red_a_i,
   output logic         red_rdy_o,
   output logic         red_fin_o,
   output logic [255:0] red_r_o,
   output logic         red_err_o
);

`ifdef RED_LAZY_OUT_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_FOLD = 2'd1} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_FOLD = 2'd1, S_SUB = 2'd2} state_t;
`endif

   state_t         r_state;
   state_t         w_state_nxt;
   logic [511:0]   r_x;
   logic [511:0]   w_x_nxt;
   logic [3:0]     r_cnt;
   logic [3:0]     w_cnt_nxt;
   logic [255:0]   r_r;
   logic [255:0]   w_r_nxt;
   logic           r_fin;
   logic           w_fin_nxt;
   logic           r_err;
   logic           w_err_nxt;
   logic           w_rdy;

   logic [255:0]   w_hi;
   logic [255:0]   w_lo;
   logic [511:0]   w_hi_ext;
   logic [511:0]   w_fold;

   assign w_hi     = r_x[511:256];
   assign w_lo     = r_x[255:0];
   assign w_hi_ext = {256'd0, w_hi};

   // 2^256 == 2^224 + 2^96 - 2^64 + 1 (mod p); the +2^96 term dominates -2^64 so this never underflows
   assign w_fold = {256'd0, w_lo} + (w_hi_ext << 224) + (w_hi_ext << 96)
                 - (w_hi_ext << 64) + w_hi_ext;

`ifndef RED_LAZY_OUT_EN
   logic [255:0]   w_sub_r;
   assign w_sub_r = (w_lo >= SM2_P) ? (w_lo - SM2_P) : w_lo;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_x_nxt     = r_x;
      w_cnt_nxt   = r_cnt;
      w_r_nxt     = r_r;
      w_fin_nxt   = 1'b0;
      w_err_nxt   = r_err;
      w_rdy       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_rdy = 1'b1;
            if (red_vld_i) begin
               w_x_nxt     = red_a_i;
               w_cnt_nxt   = 4'd0;
               w_err_nxt   = 1'b0;
               w_state_nxt = S_FOLD;
            end
         end
         S_FOLD: begin
            if (w_hi == 256'd0) begin
`ifdef RED_LAZY_OUT_EN
               w_r_nxt     = w_lo;
               w_fin_nxt   = 1'b1;
               w_state_nxt = S_IDLE;
`else
               w_state_nxt = S_SUB;
`endif
            end else if (r_cnt == 4'(FOLD_LIMIT)) begin
               w_err_nxt   = 1'b1;
               w_r_nxt     = 256'd0;
               w_fin_nxt   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_x_nxt   = w_fold;
               w_cnt_nxt = r_cnt + 4'd1;
            end
         end
`ifndef RED_LAZY_OUT_EN
         S_SUB: begin
            w_r_nxt     = w_sub_r;
            w_fin_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
         end
`endif
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_x     <= '0;
         r_cnt   <= '0;
         r_r     <= '0;
         r_fin   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_x     <= w_x_nxt;
         r_cnt   <= w_cnt_nxt;
         r_r     <= w_r_nxt;
         r_fin   <= w_fin_nxt;
         r_err   <= w_err_nxt;
      end
   end

   assign red_rdy_o = w_rdy;
   assign red_fin_o = r_fin;
   assign red_r_o   = r_r;
   assign red_err_o = r_err;

endmodule

// File: tb/tb_mod_red_sm2_512b.sv
// Randomized and directed bench for mod_red_sm2_512b against an arithmetic reference (a mod p, fold count).
module tb_mod_red_sm2_512b;

   localparam logic [255:0] P = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
`ifdef RED_LAZY_OUT_EN
   localparam bit LAZY = 1'b1;
   localparam int LAT0 = 2;
`else
   localparam bit LAZY = 1'b0;
   localparam int LAT0 = 3;
`endif

   logic         clk;
   logic         rst_n;
   logic         red_vld_i;
   logic [511:0] red_a_i;
   logic         red_rdy_o;
   logic         red_fin_o;
   logic [255:0] red_r_o;
   logic         red_err_o;

   int checks = 0;
   int errors = 0;

   mod_red_sm2_512b dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .red_vld_i (red_vld_i),
      .red_a_i   (red_a_i),
      .red_rdy_o (red_rdy_o),
      .red_fin_o (red_fin_o),
      .red_r_o   (red_r_o),
      .red_err_o (red_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (observed running, required finished)");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: residue by direct modulo; fold count by repeated hi*C + lo with C = 2^256 mod p.
   task automatic ref_model(input logic [511:0] a, output logic [255:0] r, output int f);
      logic [511:0] x;
      logic [511:0] c;
      logic [511:0] p512;
      logic [511:0] m;
      c    = (512'd1 << 224) + (512'd1 << 96) - (512'd1 << 64) + 512'd1;
      p512 = {256'd0, P};
      x    = a;
      f    = 0;
      while (x[511:256] != 256'd0 && f < 20) begin
         x = {256'd0, x[255:0]} + {256'd0, x[511:256]} * c;
         f++;
      end
      m = a % p512;
      r = LAZY ? x[255:0] : m[255:0];
   endtask

   function automatic logic [511:0] rand512();
      logic [511:0] v;
      for (int j = 0; j < 16; j++) v[j*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic run_job(input logic [511:0] a, input logic [255:0] exp_r,
                          input int exp_lat, input string tag);
      int  c;
      bit  got;
      bit  rdy_seen;
      rdy_seen = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 30; k++) begin
         if (red_rdy_o) begin
            rdy_seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk({tag, "_rdy_wait"}, 512'(rdy_seen), 512'd1);
      red_vld_i = 1'b1;
      red_a_i   = a;
      @(posedge clk);
      #1;
      red_vld_i = 1'b0;
      red_a_i   = rand512();
      chk({tag, "_busy_rdy"}, 512'(red_rdy_o), 512'd0);
      c   = 1;
      got = 1'b0;
      while (c <= 40) begin
         if (red_fin_o) begin
            got = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         c++;
      end
      chk({tag, "_fin_seen"}, 512'(got), 512'd1);
      chk({tag, "_latency"}, 512'(c), 512'(exp_lat));
      chk({tag, "_res"}, 512'(red_r_o), 512'(exp_r));
      chk({tag, "_err"}, 512'(red_err_o), 512'd0);
   endtask

   logic [511:0] a;
   logic [511:0] pm1;
   logic [255:0] mr;
   logic [255:0] first_r;
   int           mf;
   int           fins;
   bit           got;

   initial begin
      rst_n     = 1'b0;
      red_vld_i = 1'b0;
      red_a_i   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rdy", 512'(red_rdy_o), 512'd1);
      chk("rst_fin", 512'(red_fin_o), 512'd0);
      chk("rst_res", 512'(red_r_o), 512'd0);
      chk("rst_err", 512'(red_err_o), 512'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_job(512'd0, 256'd0, LAT0, "zero");
      run_job({256'd0, P}, LAZY ? P : 256'd0, LAT0, "eq_p");
      run_job({256'd0, P - 256'd1}, P - 256'd1, LAT0, "p_m1");
      run_job(512'd1 << 256,
              256'h00000001_00000000_00000000_00000000_00000000_FFFFFFFF_00000000_00000001,
              LAT0 + 1, "two256");

      pm1 = {256'd0, P - 256'd1};
      a   = pm1 * pm1;
      ref_model(a, mr, mf);
      run_job(a, LAZY ? mr : 256'd1, LAT0 + mf, "sq_pm1");

      a = {512{1'b1}};
      ref_model(a, mr, mf);
      run_job(a, mr, LAT0 + mf, "all_ones");

      for (int i = 0; i < 10; i++) begin
         a = rand512();
         if (i % 3 == 0) a[511:256] = '0;
         else if (i % 3 == 1) a[511:290] = '0;
         ref_model(a, mr, mf);
         run_job(a, mr, LAT0 + mf, $sformatf("rnd%0d", i));
      end

      // A start pulse while busy must be dropped.
      @(negedge clk);
      red_vld_i = 1'b1;
      red_a_i   = 512'd1 << 256;
      @(posedge clk);
      #1;
      red_vld_i = 1'b0;
      @(negedge clk);
      red_vld_i = 1'b1;
      red_a_i   = 512'd12345;
      @(posedge clk);
      #1;
      red_vld_i = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (red_fin_o) begin
            got = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      chk("ign_fin", 512'(got), 512'd1);
      chk("ign_res", 512'(red_r_o),
          512'(256'h00000001_00000000_00000000_00000000_00000000_FFFFFFFF_00000000_00000001));
      fins = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         if (red_fin_o) fins++;
      end
      chk("ign_nojob", 512'(fins), 512'd0);

      // Level-held start: back-to-back zero jobs, one per IDLE visit.
      @(negedge clk);
      red_vld_i = 1'b1;
      red_a_i   = '0;
      @(posedge clk);
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("held_fin%0d", k), 512'(red_fin_o), 512'((k % LAT0) == LAT0 - 1));
         chk($sformatf("held_rdy%0d", k), 512'(red_rdy_o), 512'((k % LAT0) == LAT0 - 1));
      end
      red_vld_i = 1'b0;
      repeat (6) @(posedge clk);

      // Reset during FOLD aborts the job with no completion.
      a = {512{1'b1}};
      ref_model(a, mr, mf);
      run_job(a, mr, LAT0 + mf, "pre_rst");
      first_r = red_r_o;
      @(negedge clk);
      red_vld_i = 1'b1;
      red_a_i   = a;
      @(posedge clk);
      #1;
      red_vld_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mrst_rdy", 512'(red_rdy_o), 512'd1);
      chk("mrst_fin", 512'(red_fin_o), 512'd0);
      chk("mrst_res", 512'(red_r_o), 512'd0);
      chk("mrst_err", 512'(red_err_o), 512'd0);
      @(negedge clk);
      rst_n = 1'b1;
      fins = 0;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk);
         #1;
         if (red_fin_o) fins++;
      end
      chk("mrst_nofin", 512'(fins), 512'd0);
      chk("mrst_res_hold", 512'(red_r_o), 512'd0);
      run_job(512'd1 << 256,
              256'h00000001_00000000_00000000_00000000_00000000_FFFFFFFF_00000000_00000001,
              LAT0 + 1, "post_rst");
      if (first_r == 256'd0) chk("pre_rst_nonzero", 512'(first_r), 512'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
